// File: rtl/serial_cmd_scheduler.sv
// serial_cmd_scheduler
//   Front-end between the UART receiver and the diff_freq serializers.
//   Assembles PACK_NUM-byte packets (4 pattern, 4 freq, 1 control), decodes
//   them, keeps one pending command per channel and dispatches one load per
//   cycle to an idle channel using round-robin arbitration.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_data             received byte, valid while i_rx_done_tick is high
//   i_rx_done_tick     one-cycle byte strobe
//   i_ch_busy          per-channel serializer busy
//   o_load             one-hot load strobe; o_pattern/o_freq/o_mode/o_idle_lvl
//                      are meaningful only while it is set
//   o_stop             one-hot stop strobe
//   o_frame_err        partial packet dropped on inter-byte timeout
//   o_cmd_err          invalid control byte (bad cmd or channel)
//   o_overflow         load rejected because the channel slot was occupied
module serial_cmd_scheduler #(
  parameter int DATA_BIT    = 32,
  parameter int PACK_NUM    = 9,
  parameter int CH_NUM      = 3,
  parameter int TIMEOUT_CLK = 1_000_000,
  parameter int TO_BIT      = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  input  logic [CH_NUM-1:0]   i_ch_busy,
  output logic [CH_NUM-1:0]   o_load,
  output logic [DATA_BIT-1:0] o_pattern,
  output logic [DATA_BIT-1:0] o_freq,
  output logic                o_mode,
  output logic                o_idle_lvl,
  output logic [CH_NUM-1:0]   o_stop,
  output logic                o_frame_err,
  output logic                o_cmd_err,
  output logic                o_overflow
);
  localparam int CNT_W = $clog2(PACK_NUM);
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BUF_W = 2 * DATA_BIT;

  // assembler
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              dec_vld_q, dec_vld_d;
  logic              frame_err_q, frame_err_d;

  // pending slots
  logic [CH_NUM-1:0]   slot_vld_q, slot_vld_d;
  logic [DATA_BIT-1:0] slot_pat_q  [CH_NUM];
  logic [DATA_BIT-1:0] slot_freq_q [CH_NUM];
  logic [CH_NUM-1:0]   slot_mode_q, slot_idle_q;

  // decode / dispatch
  logic [CH_NUM-1:0]   ch_oh, stop_oh, load_hit, wr_oh, req, grant_oh;
  logic                ch_ok, is_load, is_stop, cmd_err_d, overflow_d, found;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_BIT-1:0] sel_pat, sel_freq;
  logic                sel_mode, sel_idle;

  // output registers
  logic [CH_NUM-1:0]   load_q, stop_q;
  logic [DATA_BIT-1:0] pat_q, freq_q;
  logic                mode_q, idle_q, cmd_err_q, overflow_q;

  // Bytes 0..7 shift into buf_q MSB first, so pattern ends up in the upper
  // half; the control byte is captured separately and decoded next cycle.
  // buf_q is only read in the decode cycle, before any new byte can land.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    buf_d       = buf_q;
    ctrl_d      = ctrl_q;
    dec_vld_d   = 1'b0;
    frame_err_d = 1'b0;
    if (i_rx_done_tick) begin
      to_cnt_d = '0;                       // a tick always beats the timeout
      if (byte_cnt_q == CNT_W'(PACK_NUM - 1)) begin
        byte_cnt_d = '0;
        ctrl_d     = i_data;
        dec_vld_d  = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        buf_d      = {buf_q[BUF_W-9:0], i_data};
      end
    end else if (byte_cnt_q != '0) begin
      if (to_cnt_q == TO_BIT'(TIMEOUT_CLK)) begin
        byte_cnt_d  = '0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Decode: an out-of-range channel leaves ch_oh all zero.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) ch_oh[c] = (int'(ctrl_q[7:4]) == c);
    ch_ok      = |ch_oh;
    is_load    = dec_vld_q && ch_ok && (ctrl_q[1:0] == 2'b01);
    is_stop    = dec_vld_q && ch_ok && (ctrl_q[1:0] == 2'b10);
    cmd_err_d  = dec_vld_q && !is_load && !is_stop;
    stop_oh    = is_stop ? ch_oh : '0;
    load_hit   = is_load ? ch_oh : '0;
    overflow_d = |(load_hit & slot_vld_q);
    wr_oh      = load_hit & ~slot_vld_q;
  end

  // Round-robin: scan pointer..CH_NUM-1 first, then 0..pointer-1. A stop
  // decoding this cycle masks its channel so the stop wins over dispatch.
  always_comb begin
    req      = slot_vld_q & ~i_ch_busy & ~stop_oh;
    grant_oh = '0;
    found    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    sel_pat  = '0;
    sel_freq = '0;
    sel_mode = 1'b0;
    sel_idle = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (((p == 0) == (c >= int'(rr_ptr_q))) && !found && req[c]) begin
          found       = 1'b1;
          grant_oh[c] = 1'b1;
          rr_ptr_d    = PTR_W'((c + 1 == CH_NUM) ? 0 : c + 1);
          sel_pat     = slot_pat_q[c];
          sel_freq    = slot_freq_q[c];
          sel_mode    = slot_mode_q[c];
          sel_idle    = slot_idle_q[c];
        end
      end
    end
    slot_vld_d = (slot_vld_q | wr_oh) & ~grant_oh & ~stop_oh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      buf_q       <= '0;
      ctrl_q      <= '0;
      dec_vld_q   <= 1'b0;
      slot_vld_q  <= '0;
      rr_ptr_q    <= '0;
      load_q      <= '0;
      stop_q      <= '0;
      pat_q       <= '0;
      freq_q      <= '0;
      mode_q      <= 1'b0;
      idle_q      <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      buf_q       <= buf_d;
      ctrl_q      <= ctrl_d;
      dec_vld_q   <= dec_vld_d;
      slot_vld_q  <= slot_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      load_q      <= grant_oh;
      stop_q      <= stop_oh;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
      overflow_q  <= overflow_d;
      if (found) begin
        pat_q  <= sel_pat;
        freq_q <= sel_freq;
        mode_q <= sel_mode;
        idle_q <= sel_idle;
      end
    end
  end

  // Slot payload needs no reset: it is only consumed behind slot_vld_q.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_oh[c]) begin
        slot_pat_q[c]  <= buf_q[BUF_W-1 -: DATA_BIT];
        slot_freq_q[c] <= buf_q[DATA_BIT-1:0];
        slot_mode_q[c] <= ctrl_q[2];
        slot_idle_q[c] <= ctrl_q[3];
      end
    end
  end

  assign o_load      = load_q;
  assign o_pattern   = pat_q;
  assign o_freq      = freq_q;
  assign o_mode      = mode_q;
  assign o_idle_lvl  = idle_q;
  assign o_stop      = stop_q;
  assign o_frame_err = frame_err_q;
  assign o_cmd_err   = cmd_err_q;
  assign o_overflow  = overflow_q;
endmodule

// File: doc/serial_cmd_scheduler.md
Name: serial_cmd_scheduler

Overview:
- Command front-end between the UART receiver and the multi-channel diff_freq serializers.
- Assembles PACK_NUM-byte command packets from i_rx_done_tick/i_data, then decodes them.
- Holds at most one pending command per channel and dispatches loads to idle channels, using round-robin arbitration with at most one load per cycle.
- Issues immediate stop commands, and flags framing, decode and overflow errors.

Parameters:
- DATA_BIT, 32, width of the output pattern and the frequency pattern.
- PACK_NUM, 9, bytes per packet: 4 pattern + 4 frequency + 1 control.
- CH_NUM, 3, number of serializer channels (max 16).
- TIMEOUT_CLK, 1_000_000, maximum idle clocks between bytes of one packet.
- TO_BIT, 20, width of the timeout counter; must satisfy TO_BIT >= log2(TIMEOUT_CLK+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_data  in  8  received UART byte.
- i_rx_done_tick  in  1  one-cycle strobe; i_data is valid in that cycle.
- i_ch_busy  in  CH_NUM  per-channel busy from the serializers; high while a pattern is being shifted.
- o_load  out  CH_NUM  one-hot, one-cycle load strobe.
- o_pattern  out  DATA_BIT  output pattern for the channel being loaded.
- o_freq  out  DATA_BIT  frequency pattern (0 = low speed, 1 = high speed per bit).
- o_mode  out  1  0 = one-shot, 1 = repeat.
- o_idle_lvl  out  1  serial idle level.
- o_stop  out  CH_NUM  one-hot, one-cycle stop strobe.
- o_frame_err  out  1  one-cycle pulse: a partial packet was discarded on timeout.
- o_cmd_err  out  1  one-cycle pulse: invalid control byte.
- o_overflow  out  1  one-cycle pulse: packet rejected because the channel's slot was full.

Behaviour:
- Reset (rst_n low at clk edge):
  - All outputs 0, byte counter 0, timeout counter 0.
  - All pending slots invalid; round-robin pointer = 0.
  - Reset mid-packet or mid-dispatch discards everything; nothing is emitted.
- Assembler:
  - Byte counter runs 0..PACK_NUM-1 and advances only on i_rx_done_tick.
  - Bytes 0-3 form the pattern, MSB first: byte0 = [31:24].
  - Bytes 4-7 form the frequency, MSB first.
  - Byte 8 is the control byte.
  - On byte PACK_NUM-1 the counter wraps to 0 and the packet is registered for decode on the next cycle.
- Timeout:
  - The timeout counter runs while the byte counter is nonzero, clears on every tick, and holds at 0 while the byte counter is 0.
  - On reaching TIMEOUT_CLK: byte counter is set to 0, partial data is dropped, o_frame_err pulses.
  - If a tick coincides with the timeout, the tick wins: the byte is accepted and there is no error.
- Control byte layout:
  - [7:4] channel; [3] idle level; [2] mode; [1:0] cmd.
  - cmd 01 = load/start; cmd 10 = stop; cmd 00 and 11 are invalid.
  - Invalid cmd or channel >= CH_NUM: pulse o_cmd_err and discard the packet.
- Decode cycle (D = cycle after the 9th tick):
  - Load, slot empty: write pattern/freq/mode/idle into slot[ch]; slot is valid from D+1.
  - Load, slot full: pulse o_overflow in D+1; the existing slot is unchanged.
  - Stop: o_stop[ch] high in D+1, slot[ch] invalidated, o_load never asserted for that packet.
- Dispatch:
  - Each cycle, the arbiter picks the first channel at or after the round-robin pointer with slot valid and i_ch_busy low.
  - It registers o_load[ch] and the data outputs, invalidates the slot, and sets the pointer to ch+1 mod CH_NUM.
  - Best-case latency: o_load is high in cycle D+2, i.e. 3 cycles after the 9th tick.
  - o_pattern/o_freq/o_mode/o_idle_lvl are valid only while o_load is set; they hold their previous value otherwise.
  - A slot written in the same cycle its channel is dispatched cannot occur, because the write happens in D and dispatch reads from D+1 onward.
- Busy channel: the slot waits until i_ch_busy[ch] falls and dispatch follows in the next arbitration.
- Stop vs dispatch: if a stop for ch decodes in the same cycle the arbiter selects ch, the stop wins. o_load is suppressed, the slot is cleared, and o_stop pulses.
- Channels proceed independently; only one o_load bit and at most one o_stop bit are ever high per cycle.

Test Plan:
- Ch0 load: send bytes FF 00 FF 00 00 00 00 00 01 with i_ch_busy=0.
  - Expect o_load=3'b001 exactly 3 cycles after the 9th tick.
  - Expect o_pattern=32'hFF00FF00, o_freq=0, o_mode=0, o_idle_lvl=0.
- Ch1 repeat: control 0x15 with i_ch_busy[1]=1.
  - No load while busy.
  - Drop busy → o_load=3'b010 next arbitration with o_mode=1.
  - A second 0x15 packet while the slot is full → o_overflow pulse, original data kept.
- Round-robin: slots 0 and 2 pending, both unblocked in the same cycle, pointer=1.
  - o_load=3'b100, then 3'b001 in the next cycle.
- Stop: pending ch2 load held busy, then control 0x22 → o_stop=3'b100.
  - Slot cleared; no o_load[2] after busy drops.
- Errors:
  - Control 0x03 or 0x31 (with CH_NUM=3) → o_cmd_err, no load.
  - 5 bytes, then TIMEOUT_CLK idle clocks → o_frame_err.
  - A following full packet decodes correctly.
- Reset: assert rst_n=0 mid-packet (byte 4) and with a slot pending.
  - All outputs 0, no o_load after release.
  - Next packet aligns from byte 0.
